// File: rtl/dadda_mac_sequencer.sv
// Dot-product sequencer around an external combinational 8x8 Dadda MAC datapath.
// Streams (a, b) pairs through the datapath, feeding the registered accumulator back into x.
module dadda_mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic [ACC_W-1:0] mac_x,
  input  logic [ACC_W-1:0] mac_out,
  input  logic             mac_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic             r_ovf;

  logic w_in_acc;
  logic w_in_done;
  logic w_beat;
  logic w_last;

  assign w_in_acc  = (r_state == S_ACC);
  assign w_in_done = (r_state == S_DONE);
  assign w_beat    = w_in_acc && in_valid;
  // Only reachable in ACC, where r_len_q >= 1, so the decrement never wraps.
  assign w_last    = (r_cnt == (r_len_q - LEN_W'(1)));

  assign in_ready  = w_in_acc;
  assign busy      = w_in_acc || w_in_done;
  assign res_valid = w_in_done;
  assign res_data  = w_in_done ? r_acc : '0;
  assign res_ovf   = w_in_done && r_ovf;

  // Operands pass straight through to the datapath only while a beat can be taken.
  assign mac_a = w_in_acc ? in_a : 8'd0;
  assign mac_b = w_in_acc ? in_b : 8'd0;
  assign mac_x = r_acc;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len_q <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len_q <= len;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_state <= (len == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (w_beat) begin
            r_acc <= mac_out;
            r_ovf <= r_ovf | mac_cout;
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_mac_sequencer.sv
// Self-checking bench for dadda_mac_sequencer with a behavioural a*b+x datapath model.
// Table-driven runs plus directed sequences for len=0, backpressure and mid-run reset.
module tb_dadda_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic [15:0] mac_x;
  logic [15:0] mac_out;
  logic        mac_cout;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_ovf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  dadda_mac_sequencer #(.LEN_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_x(mac_x),
    .mac_out(mac_out), .mac_cout(mac_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
  );

  // Behavioural stand-in for the combinational Dadda MAC datapath.
  always_comb begin
    {mac_cout, mac_out} = 17'(mac_a) * 17'(mac_b) + 17'(mac_x);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    int              n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int              gap;
    logic [15:0]     exp_data;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_run(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    len   = 8'(v.n);
    @(negedge clk);
    start = 1'b0;
    check({v.name, " in_ready in ACC"}, 32'(in_ready), 32'd1);
    check({v.name, " busy in ACC"}, 32'(busy), 32'd1);
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_a     = v.a[i];
      in_b     = v.b[i];
      check({v.name, " res_valid before beat"}, 32'(res_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 8'hA5;
      in_b     = 8'h5A;
      if (i != v.n - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          check({v.name, " in_ready in gap"}, 32'(in_ready), 32'd1);
          @(negedge clk);
        end
      end
    end
    check({v.name, " res_valid"}, 32'(res_valid), 32'd1);
    check({v.name, " res_data"}, 32'(res_data), 32'(v.exp_data));
    check({v.name, " res_ovf"}, 32'(res_ovf), 32'(v.exp_ovf));
    check({v.name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({v.name, " res_valid after ack"}, 32'(res_valid), 32'd0);
    check({v.name, " busy after ack"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;

    vecs[0].name = "len1";     vecs[0].n = 1; vecs[0].gap = 0;
    vecs[0].a = {8'd0, 8'd0, 8'd0, 8'd70};
    vecs[0].b = {8'd0, 8'd0, 8'd0, 8'd20};
    vecs[0].exp_data = 16'h0578; vecs[0].exp_ovf = 1'b0;

    vecs[1].name = "len3_b2b"; vecs[1].n = 3; vecs[1].gap = 0;
    vecs[1].a = {8'd0, 8'd74, 8'd215, 8'd79};
    vecs[1].b = {8'd0, 8'd113, 8'd200, 8'd69};
    vecs[1].exp_data = 16'hDDED; vecs[1].exp_ovf = 1'b0;

    vecs[2] = vecs[1];
    vecs[2].name = "len3_gap"; vecs[2].gap = 2;

    vecs[3].name = "len2_ovf"; vecs[3].n = 2; vecs[3].gap = 0;
    vecs[3].a = {8'd0, 8'd0, 8'd255, 8'd255};
    vecs[3].b = {8'd0, 8'd0, 8'd255, 8'd255};
    vecs[3].exp_data = 16'hFC02; vecs[3].exp_ovf = 1'b1;

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = 8'h11; in_b = 8'h22; res_ready = 1'b0;
    #12;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset mac_a", 32'(mac_a), 32'd0);
    check("reset mac_x", 32'(mac_x), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) do_run(vecs[i]);

    // len == 0: result on the cycle after start, nothing consumed.
    @(negedge clk);
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0 res_valid", 32'(res_valid), 32'd1);
    check("len0 res_data", 32'(res_data), 32'd0);
    check("len0 res_ovf", 32'(res_ovf), 32'd0);
    check("len0 in_ready", 32'(in_ready), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("len0 idle after ack", 32'(busy), 32'd0);

    // Backpressure in DONE with start and in_valid poked.
    @(negedge clk);
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255;
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      start = c[0]; len = 8'd5; in_valid = 1'b1; in_a = 8'd3; in_b = 8'd4;
      @(negedge clk);
      check("bp res_valid", 32'(res_valid), 32'd1);
      check("bp res_data", 32'(res_data), 32'h0000FC02);
      check("bp res_ovf", 32'(res_ovf), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp mac_a", 32'(mac_a), 32'd0);
    end
    start = 1'b1; res_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; res_ready = 1'b0;
    check("bp start+ack busy", 32'(busy), 32'd0);
    check("bp start+ack res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("bp stays idle", 32'(busy), 32'd0);

    // Asynchronous reset after 2 of 3 beats.
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 8'd79; in_b = 8'd69;
      @(negedge clk);
    end
    in_valid = 1'b1; in_a = 8'd74; in_b = 8'd113;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data", 32'(res_data), 32'd0);
    check("rst res_ovf", 32'(res_ovf), 32'd0);
    check("rst mac_a", 32'(mac_a), 32'd0);
    check("rst mac_b", 32'(mac_b), 32'd0);
    check("rst mac_x", 32'(mac_x), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    v.name = "post_rst"; v.n = 1; v.gap = 0;
    v.a = {8'd0, 8'd0, 8'd0, 8'd93};
    v.b = {8'd0, 8'd0, 8'd0, 8'd7};
    v.exp_data = 16'h028B; v.exp_ovf = 1'b0;
    do_run(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dadda_mac_sequencer.md
Name: dadda_mac_sequencer

Overview:
Sequences the combinational 8x8 Dadda multiply-accumulate datapath (a*b + x -> 16-bit sum plus carry-out) to compute a multi-term dot product.
- Accepts a stream of (a, b) operand pairs over a valid/ready handshake.
- Feeds its own registered accumulator back into the datapath's x input.
- Presents the final 16-bit sum and a sticky overflow flag over a second valid/ready handshake.
- Sits between an operand source (memory reader or test driver) and the dadda MAC instance.

Parameters:
LEN_W, 8, width of the run-length input; runs of 0..2^LEN_W-1 terms.
ACC_W, 16, accumulator and result width; must match the datapath sum width.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a run when in IDLE, ignored otherwise
len  input  LEN_W  number of operand pairs in the run, sampled when start is accepted
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer accepts an operand pair this cycle
in_a  input  8  multiplicand
in_b  input  8  multiplier
mac_a  output  8  to datapath a
mac_b  output  8  to datapath b
mac_x  output  ACC_W  to datapath x (accumulator feedback)
mac_out  input  ACC_W  datapath sum
mac_cout  input  1  datapath carry-out
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  ACC_W  accumulated sum, modulo 2^ACC_W
res_ovf  output  1  sticky OR of mac_cout over all accepted beats of the run
busy  output  1  high in ACC or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; acc, cnt, len_q, ovf cleared. All outputs read 0: in_ready, res_valid, busy, res_data, res_ovf, mac_a, mac_b, mac_x. Reset asserted mid-run abandons the run with no partial result.
- States: IDLE, ACC, DONE.
- IDLE: in_ready=0, res_valid=0.
  - start=1: len_q<=len, acc<=0, ovf<=0, cnt<=0.
  - Next state is DONE if len==0, else ACC.
- ACC: in_ready=1, busy=1.
  - mac_a=in_a and mac_b=in_b, combinational pass-through; both are 0 outside ACC.
  - mac_x=acc in all states.
  - Beat accepted (in_valid&in_ready): acc<=mac_out, ovf<=ovf|mac_cout, cnt<=cnt+1.
  - Beat with cnt==len_q-1 goes to DONE.
  - No beat: acc, cnt, ovf hold (bubbles allowed).
- DONE: res_valid=1, res_data=acc, res_ovf=ovf, in_ready=0.
  - Outputs are stable while res_ready=0.
  - res_ready=1 goes to IDLE on the next edge; res_valid drops that edge.
- Throughput: one beat per cycle.
- Latency: res_valid asserts on the edge that accepts the last beat, i.e. it is visible the cycle after that beat. For len==0, res_valid is visible the cycle after start with res_data=0, res_ovf=0.
- start while busy: ignored with no side effects. start and res_ready in the same DONE cycle: start is ignored; it is honoured only when sampled in IDLE.
- Arithmetic: acc wraps modulo 2^ACC_W. Overflow is reported only via res_ovf; the sum is never saturated.
- in_a/in_b while in_ready=0 do not affect state.

Test Plan:
- len=1, beat (70,20) -> res_data=0x0578 (1400), res_ovf=0, res_valid one cycle after beat.
- len=3, beats (79,69),(215,200),(74,113) back-to-back -> res_data=0xDDED (56813), res_ovf=0. Repeat with 2-cycle in_valid gaps between beats -> same result; in_ready stays 1 through the gaps.
- len=2, beats (255,255),(255,255) -> first beat gives acc=0xFE01 with no carry; second sets carry -> res_data=0xFC02, res_ovf=1.
- len=0 start -> next cycle res_valid=1, res_data=0x0000, res_ovf=0, no beats consumed.
- Backpressure: hold res_ready=0 for 5 cycles in DONE and pulse start and in_valid -> res_data/res_ovf stable, in_ready=0, start ignored. Release res_ready -> IDLE and busy=0 next cycle.
- Assert rst_n low asynchronously after 2 of 3 beats -> all outputs 0 immediately, state IDLE. A fresh len=1 (93,7) run then gives res_data=0x028B (651), res_ovf=0.
